// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-high here; polarity is applied at the pins.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index = nibble value; bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {BLANK, SHOW} slot_state_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot/digit sequencer: tick within slot, digit index, BLANK/SHOW phase.
// Latency: state is registered alongside tick; frame_done follows boundary by 1 cycle.
// Backpressure: none, free-running once out of reset.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 48000,
  parameter int BLANK_TICKS     = 1200,
  parameter int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1,
  parameter int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [TW-1:0] tick,
  output logic [IW-1:0] idx,
  output slot_state_t   state,
  output logic          boundary,
  output logic          frame_done
);

  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);

  logic [TW-1:0] tick_d;
  logic [IW-1:0] idx_d;
  slot_state_t   state_d;

  always_comb begin
    tick_d   = tick + TW'(1);
    idx_d    = idx;
    boundary = (tick == TICK_MAX) && (idx == IDX_MAX);
    if (tick == TICK_MAX) begin
      tick_d = '0;
      idx_d  = (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end
    // Phase is decided from the tick value the counter is about to hold.
    state_d = (tick_d < BLANK_END) ? BLANK : SHOW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick       <= '0;
      idx        <= '0;
      state      <= BLANK;
      frame_done <= 1'b0;
    end else begin
      tick       <= tick_d;
      idx        <= idx_d;
      state      <= state_d;
      frame_done <= boundary;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex seven-segment driver with blanking and frame-synchronous double buffering.
// Latency: pins lag the slot FSM by 1 cycle; a load shows from the next frame (1 cycle on boundary bypass).
// Backpressure: none; load is a fire-and-forget strobe, the last load in a frame wins.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 48000,
  parameter int BLANK_TICKS     = 1200,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SEL_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TW-1:0] tick;
  logic [IW-1:0] idx;
  slot_state_t   state;
  logic          boundary;

  logic [NUM_DIGITS-1:0][3:0] shadow_dig, active_dig;
  logic [NUM_DIGITS-1:0]      shadow_en, active_en;
  logic [6:0]                 seg_d, seg_q;
  logic [NUM_DIGITS-1:0]      sel_d, sel_q;

  seg_slot_timer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT),
    .BLANK_TICKS    (BLANK_TICKS),
    .TW             (TW),
    .IW             (IW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .idx       (idx),
    .state     (state),
    .boundary  (boundary),
    .frame_done(frame_done)
  );

  // Active only changes on the boundary, which is always followed by a BLANK slot start.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_dig <= '0;
      shadow_en  <= '0;
      active_dig <= '0;
      active_en  <= '0;
    end else begin
      if (load) begin
        shadow_dig <= digits_in;
        shadow_en  <= digit_en_in;
      end
      if (boundary) begin
        active_dig <= load ? digits_in   : shadow_dig;
        active_en  <= load ? digit_en_in : shadow_en;
      end
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    sel_d = '0;
    if (state == SHOW && active_en[idx]) begin
      sel_d[idx] = 1'b1;
      seg_d      = HEX_SEG[active_dig[idx]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_OFF;
      sel_q <= '0;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign sel = SEL_ACTIVE_LOW ? ~sel_q : sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboarded bench: stimulus pushes per-cycle expected pins from a frame-level model, a monitor compares.
module tb_seg_scan_driver;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int B  = 2;
  localparam int FR = N * T;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   digits_in = '0;
  logic [3:0]    digit_en_in = '0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic [3:0]    sel;
  logic          frame_done;

  seg_scan_driver #(
    .NUM_DIGITS     (N),
    .TICKS_PER_DIGIT(T),
    .BLANK_TICKS    (B),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .digit_en_in(digit_en_in),
    .load       (load),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [6:0] seg;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic [3:0]  e;
  } load_t;

  // Active-low glyphs, 0-9 A b C d E F.
  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t  exp_q [$];
  load_t loads [$];
  int    c = 0;
  logic  prev_rst = 1'b1;
  logic  done = 1'b0;
  int    tests = 0;
  int    fails = 0;

  // Pins at cycle c show what cycle c-1 scheduled; a frame shows the last load issued before it began.
  function automatic exp_t exp_at(int cc);
    exp_t        x;
    int          p, fs, t, s;
    logic [15:0] d;
    logic [3:0]  e;
    x.c = cc; x.seg = 7'h7F; x.sel = 4'hF; x.fd = 1'b0;
    if (cc > 0) begin
      p  = cc - 1;
      fs = p - (p % FR);
      d  = '0;
      e  = '0;
      foreach (loads[i]) if (loads[i].cyc < fs) begin d = loads[i].d; e = loads[i].e; end
      t  = p % T;
      s  = (p % FR) / T;
      x.fd = (cc % FR == 0);
      if (t >= B && e[s]) begin
        x.sel = ~(4'b0001 << s);
        x.seg = glyph[d[4*s +: 4]];
      end
    end
    return x;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic [3:0] e);
    load_t l;
    @(posedge clk);
    #1;
    if (prev_rst) begin
      c = 0;
      loads.delete();
    end else begin
      c++;
    end
    exp_q.push_back(exp_at(c));
    reset = rst;
    load = ld;
    digits_in = d;
    digit_en_in = e;
    if (ld && !rst) begin
      l.cyc = c; l.d = d; l.e = e;
      loads.push_back(l);
    end
    prev_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Idle until the next step lands on the given cycle-in-frame.
  task automatic wait_phase(input int k);
    while ((c + 1) % FR != k) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
    idle(100);
    wait_phase(5);
    step(1'b0, 1'b1, 16'h8F30, 4'hF);
    idle(70);
    wait_phase(10);
    step(1'b0, 1'b1, 16'h8F30, 4'b0101);
    idle(70);
    wait_phase(12);
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    idle(1);
    step(1'b0, 1'b1, 16'h2222, 4'hF);
    idle(60);
    wait_phase(31);
    step(1'b0, 1'b1, 16'hABCD, 4'hF);
    idle(40);
    wait_phase(20);
    step(1'b1, 1'b0, '0, '0);
    idle(80);
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (((c + 1) % FR == FR - 1 && r < 40) || r < 8)
        step(1'b0, 1'b1, $urandom, $urandom);
      else if (r == 99)
        step(1'b1, 1'b0, '0, '0);
      else
        idle(1);
    end
    idle(2);
    done = 1'b1;
  end

  initial begin
    exp_t       x;
    logic [6:0] pseg = 7'h7F;
    logic [3:0] psel = 4'hF;
    int         guard = 0;
    forever begin
      @(negedge clk);
      guard++;
      if (exp_q.size() == 0) begin
        if (guard > 3) begin
          tests++; fails++;
          $display("FAIL scoreboard_empty at t=%0t: no expectation queued", $time);
        end
      end else begin
        x = exp_q.pop_front();
        tests++;
        if (seg !== x.seg || sel !== x.sel || frame_done !== x.fd) begin
          fails++;
          $display("FAIL pins c=%0d: got seg=%h sel=%h fd=%b, want seg=%h sel=%h fd=%b",
                   x.c, seg, sel, frame_done, x.seg, x.sel, x.fd);
        end
        tests++;
        if (!$onehot0(~sel)) begin
          fails++;
          $display("FAIL sel_onehot c=%0d: got sel=%h, want at most one low bit", x.c, sel);
        end
        if (sel != 4'hF && sel == psel) begin
          tests++;
          if (seg !== pseg) begin
            fails++;
            $display("FAIL seg_stable c=%0d: got seg=%h, want %h while sel=%h", x.c, seg, pseg, sel);
          end
        end
      end
      pseg = seg;
      psel = sel;
      if (done || guard > 20000) begin
        tests++;
        if (exp_q.size() != 0 || !done) begin
          fails++;
          $display("FAIL drain: got %0d pending (done=%b), want 0 pending", exp_q.size(), done);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

endmodule
